// File: rtl/vga_frame_reader.sv
// vga_frame_reader: display-side client of the double-buffered frame store.
// Generates VGA timing, streams linear read addresses for the display half,
// re-aligns returned pixels with delayed sync/DE, and flips the buffer-select
// flag only at the start of vertical blanking once the drawer reports a frame.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 2,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [18:0]       vga_addr,
    output logic              swap,
    output logic              frame_ack,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DATA_W-1:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Last pixel address of the visible area; the address counter wraps here.
    localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              fetch_act;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              swap_point;
    logic [RD_LAT-1:0] de_pipe;
    logic [RD_LAT-1:0] hs_pipe;
    logic [RD_LAT-1:0] vs_pipe;
    logic              rgb_gate;
    state_t            state;
    state_t            state_next;
    logic              do_swap;

    // Fetch-domain decodes straight off the raster counters.
    assign fetch_act  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vsync_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    // First pixel of the first blank line: the delayed DE of the last visible
    // pixel has long drained, so flipping halves here can never tear a frame.
    assign swap_point = (v_cnt == V_ACT) && (h_cnt == '0);

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Read address as a plain counter stepped on visible pixels; it parks on
    // the next line's start during hblank and on 0 after the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_addr <= '0;
        end else if (fetch_act) begin
            vga_addr <= (vga_addr == ADDR_LAST) ? '0 : vga_addr + 19'd1;
        end
    end

    // Delay lines carrying DE and syncs across the memory read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_pipe <= '0;
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            de_pipe[0] <= fetch_act;
            hs_pipe[0] <= hsync_raw;
            vs_pipe[0] <= vsync_raw;
            for (int i = 1; i < RD_LAT; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    // The rgb register is loaded one cycle ahead of DE, so it is gated by
    // the delay-line stage just before the output stage.
    if (RD_LAT == 1) begin : g_gate_direct
        assign rgb_gate = fetch_act;
    end else begin : g_gate_pipe
        assign rgb_gate = de_pipe[RD_LAT-2];
    end

    assign de    = de_pipe[RD_LAT-1];
    assign hsync = hs_pipe[RD_LAT-1];
    assign vsync = vs_pipe[RD_LAT-1];

    // Pixel output register, blanked outside the active area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_gate ? mem_rdata : '0;
        end
    end

    // Swap FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Swap FSM next state: a finished frame is remembered until the swap point.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_ready && !swap_point) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (swap_point) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Swap FSM output: a request arriving exactly at the swap point counts too.
    always_comb begin
        do_swap = swap_point && ((state == PENDING) || frame_ready);
    end

    // Buffer-select flag and its one-cycle acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap      <= 1'b0;
            frame_ack <= 1'b0;
        end else begin
            swap      <= swap ^ do_swap;
            frame_ack <= do_swap;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a reduced-raster instance checked every cycle
// against a position-based reference model, plus a full 640x480 instance
// pinned with hand-computed values over its first lines.
module tb_vga_frame_reader;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VA  = 6;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int F   = HT * VT;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        fr;
    logic        fr_f;
    logic [11:0] mem_rd;
    logic [11:0] mem_rd_f;
    logic [18:0] addr,   addr_f;
    logic        swap,   swap_f;
    logic        ack,    ack_f;
    logic        hs,     hs_f;
    logic        vs,     vs_f;
    logic        de,     de_f;
    logic [11:0] rgb,    rgb_f;

    int          checks;
    int          failures;
    logic [31:0] seed;

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RD_LAT(LAT), .DATA_W(12)
    ) dut (
        .clk(clk), .reset(rst), .frame_ready(fr), .mem_rdata(mem_rd),
        .vga_addr(addr), .swap(swap), .frame_ack(ack),
        .hsync(hs), .vsync(vs), .de(de), .rgb(rgb)
    );

    vga_frame_reader dut_full (
        .clk(clk), .reset(rst), .frame_ready(fr_f), .mem_rdata(mem_rd_f),
        .vga_addr(addr_f), .swap(swap_f), .frame_ack(ack_f),
        .hsync(hs_f), .vsync(vs_f), .de(de_f), .rgb(rgb_f)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Frame-store contents: a seeded hash of the address.
    function automatic logic [11:0] mem_val(input logic [18:0] a);
        logic [31:0] t;
        t = ({13'd0, a} * 32'h9E3779B1) ^ seed;
        return t[27:16];
    endfunction

    // Memory side: registered lookup, data presented RD_LAT-1 cycles after
    // the address so that the DUT's output register adds the last cycle.
    always @(posedge clk) begin
        mem_rd   <= mem_val(addr);
        mem_rd_f <= mem_val(addr_f);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model in raster terms: cycle n after reset release.
    function automatic int pos_h(input int n);
        return (n % F) % HT;
    endfunction

    function automatic int pos_v(input int n);
        return (n % F) / HT;
    endfunction

    function automatic int exp_addr(input int n);
        int h, v;
        h = pos_h(n);
        v = pos_v(n);
        if (v >= VA) return 0;
        if (h < HA) return v * HA + h;
        return ((v + 1) * HA) % (HA * VA);
    endfunction

    function automatic bit raw_act(input int n);
        return (pos_h(n) < HA) && (pos_v(n) < VA);
    endfunction

    function automatic bit raw_hs(input int n);
        int h;
        h = pos_h(n);
        return !((h >= HA + HFP) && (h < HA + HFP + HS));
    endfunction

    function automatic bit raw_vs(input int n);
        int v;
        v = pos_v(n);
        return !((v >= VA + VFP) && (v < VA + VFP + VS));
    endfunction

    int          n;
    bit          m_swap;
    bit          m_pend;
    bit          m_ack;
    bit          e_de;
    bit          e_hs;
    bit          e_vs;
    logic [11:0] e_rgb;

    // Compare process: checks the reduced instance against the model each cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_addr", 32'(addr), 0);
            chk("rst_swap", 32'(swap), 0);
            chk("rst_ack", 32'(ack), 0);
            chk("rst_hsync", 32'(hs), 1);
            chk("rst_vsync", 32'(vs), 1);
            chk("rst_de", 32'(de), 0);
            chk("rst_rgb", 32'(rgb), 0);
            n      = 0;
            m_swap = 1'b0;
            m_pend = 1'b0;
            m_ack  = 1'b0;
        end else begin
            e_de  = (n >= LAT) ? raw_act(n - LAT) : 1'b0;
            e_hs  = (n >= LAT) ? raw_hs(n - LAT)  : 1'b1;
            e_vs  = (n >= LAT) ? raw_vs(n - LAT)  : 1'b1;
            e_rgb = e_de ? mem_val(19'(exp_addr(n - LAT))) : 12'd0;
            chk("addr", 32'(addr), exp_addr(n));
            chk("de", 32'(de), 32'(e_de));
            chk("hsync", 32'(hs), 32'(e_hs));
            chk("vsync", 32'(vs), 32'(e_vs));
            chk("rgb", 32'(rgb), 32'(e_rgb));
            chk("swap", 32'(swap), 32'(m_swap));
            chk("frame_ack", 32'(ack), 32'(m_ack));
            // Buffer flip rule, applied at the edge closing this cycle.
            if (pos_v(n) == VA && pos_h(n) == 0 && (m_pend || fr)) begin
                m_swap = !m_swap;
                m_ack  = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_ack = 1'b0;
                if (fr) m_pend = 1'b1;
            end
            n++;
        end
    end

    // Hand-computed expectations for the full-size raster, first lines.
    task automatic full_pins(input int c);
        case (c)
            0:   begin chk("f_addr0", 32'(addr_f), 0); chk("f_swap0", 32'(swap_f), 0); end
            1:   chk("f_de1", 32'(de_f), 0);
            2:   begin chk("f_de2", 32'(de_f), 1); chk("f_rgb2", 32'(rgb_f), 32'(mem_val(19'd0))); end
            639: chk("f_addr639", 32'(addr_f), 639);
            640: chk("f_addr640", 32'(addr_f), 640);
            641: begin chk("f_de641", 32'(de_f), 1); chk("f_rgb641", 32'(rgb_f), 32'(mem_val(19'd639))); end
            642: begin chk("f_de642", 32'(de_f), 0); chk("f_rgb642", 32'(rgb_f), 0); end
            657: chk("f_hs657", 32'(hs_f), 1);
            658: chk("f_hs658", 32'(hs_f), 0);
            700: chk("f_vs700", 32'(vs_f), 1);
            753: chk("f_hs753", 32'(hs_f), 0);
            754: chk("f_hs754", 32'(hs_f), 1);
            799: chk("f_addr799", 32'(addr_f), 640);
            801: begin chk("f_addr801", 32'(addr_f), 641); chk("f_de801", 32'(de_f), 0); end
            802: chk("f_de802", 32'(de_f), 1);
            default: ;
        endcase
    endtask

    // Hand-computed expectations for the reduced raster and its swap sequence.
    task automatic small_pins(input int c);
        case (c)
            5 * HT + HA - 1:      chk("s_addr_last", 32'(addr), 95);
            5 * HT + HA:          chk("s_addr_wrap", 32'(addr), 0);
            8 * HT + 1:           chk("s_vs_before", 32'(vs), 1);
            8 * HT + 2:           chk("s_vs_low", 32'(vs), 0);
            F + VA * HT:          chk("s_swap_f1_pre", 32'(swap), 0);
            F + VA * HT + 1:      begin chk("s_swap_f1", 32'(swap), 1); chk("s_ack_f1", 32'(ack), 1); end
            F + VA * HT + 2:      chk("s_ack_f1_end", 32'(ack), 0);
            2 * F + VA * HT + 1:  begin chk("s_swap_f2", 32'(swap), 0); chk("s_ack_f2", 32'(ack), 1); end
            3 * F + VA * HT + 1:  chk("s_swap_f3", 32'(swap), 1);
            4 * F + VA * HT + 1:  begin chk("s_swap_f4", 32'(swap), 1); chk("s_ack_f4", 32'(ack), 0); end
            5 * F + VA * HT + 1:  begin chk("s_swap_f5", 32'(swap), 0); chk("s_ack_f5", 32'(ack), 1); end
            default: ;
        endcase
    endtask

    // Frame-ready schedule for the first run, frame by frame.
    function automatic logic sched(input int c, input bit need_flip);
        int f, h, v;
        f = c / F;
        h = pos_h(c);
        v = pos_v(c);
        case (f)
            1: return (v == 2 && h == 5);
            2: return (v == VA && h == 0);
            3: return (v == 1 && h == 0) || (v == 3 && h == 7) || (v == VA && h == 0);
            4: return (v == VA + 3 && h == 4);
            6, 7, 8, 9: return ($urandom_range(0, 99) == 0);
            11: return need_flip && (v == 1 && h == 0);
            default: return 1'b0;
        endcase
    endfunction

    bit need_flip;

    initial begin
        checks    = 0;
        failures  = 0;
        seed      = $urandom;
        rst       = 1'b1;
        fr        = 1'b0;
        fr_f      = 1'b0;
        need_flip = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        for (int c = 0; c < 12 * F + 3 * HT + 8; c++) begin
            full_pins(c);
            small_pins(c);
            if (c == 11 * F) need_flip = !m_swap;
            fr = sched(c, need_flip);
            @(posedge clk);
            #2;
        end

        // Mid-frame reset with the display on the high half.
        fr = 1'b0;
        chk("pre_reset_swap", 32'(swap), 1);
        chk("pre_reset_de", 32'(de), 1);
        rst = 1'b1;
        #1;
        chk("async_addr", 32'(addr), 0);
        chk("async_swap", 32'(swap), 0);
        chk("async_de", 32'(de), 0);
        chk("async_rgb", 32'(rgb), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        for (int c = 0; c < 2 * F; c++) begin
            case (c)
                0:               begin chk("post_addr0", 32'(addr), 0); chk("post_swap0", 32'(swap), 0); end
                1:               chk("post_addr1", 32'(addr), 1);
                VA * HT + 1:     begin chk("post_swap", 32'(swap), 1); chk("post_ack", 32'(ack), 1); end
                default: ;
            endcase
            fr = (c == 2 * HT);
            @(posedge clk);
            #2;
        end
        fr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
